// File: rtl/seq_muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit: op codes, FSM states
// and small op-decode helpers used by both the controller and the datapath.
package seq_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Datapath for seq_muldiv: operand magnitude capture, one shared (N+1)-bit
// adder/subtractor, the hi/lo accumulator and the final sign correction.
module muldiv_datapath
  import seq_muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         iter,
  input  logic         fix,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         dz_hit
);

  logic [1:0]   op_q, op_d;
  logic [N-1:0] amag_q, amag_d;
  logic [N-1:0] bmag_q, bmag_d;
  logic [N-1:0] araw_q, araw_d;
  logic         rsign_q, rsign_d;
  logic         dsign_q, dsign_d;
  logic [N-1:0] acc_hi_q, acc_hi_d;
  logic [N-1:0] acc_lo_q, acc_lo_d;
  logic [N-1:0] hi_q, hi_d;
  logic [N-1:0] lo_q, lo_d;

  logic         is_mul;
  logic         sgn;
  logic [N-1:0] a_abs, b_abs;
  logic [N:0]   add_x, add_y, sum;
  logic         cin;
  logic         ge;
  logic [2*N-1:0] prod;

  assign is_mul = ~is_div_op(op_q);
  assign dz_hit = is_div_op(op_q) && (bmag_q == '0);

  // Multiply adds the multiplicand into the upper half; divide subtracts the
  // divisor from the shifted remainder {rem, quo[N-1]} via x + ~d + 1.
  always_comb begin
    add_x = is_mul ? {1'b0, acc_hi_q} : {acc_hi_q, acc_lo_q[N-1]};
    add_y = is_mul ? {1'b0, amag_q} : ~{1'b0, bmag_q};
    cin   = ~is_mul;
    sum   = add_x + add_y + (N+1)'(cin);
    // A set rem MSB means the shifted remainder already exceeds any divisor.
    ge    = acc_hi_q[N-1] | ~sum[N];
    prod  = {acc_hi_q, acc_lo_q};
  end

  always_comb begin
    sgn   = is_signed_op(op);
    a_abs = (sgn && a[N-1]) ? -a : a;
    b_abs = (sgn && b[N-1]) ? -b : b;
  end

  always_comb begin
    op_d     = op_q;
    amag_d   = amag_q;
    bmag_d   = bmag_q;
    araw_d   = araw_q;
    rsign_d  = rsign_q;
    dsign_d  = dsign_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (load) begin
      op_d     = op;
      amag_d   = a_abs;
      bmag_d   = b_abs;
      araw_d   = a;
      rsign_d  = sgn & (a[N-1] ^ b[N-1]);
      dsign_d  = sgn & a[N-1];
      acc_hi_d = '0;
      acc_lo_d = is_div_op(op) ? a_abs : b_abs;
    end else if (iter) begin
      if (is_mul) begin
        if (acc_lo_q[0]) {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[N-1:1]};
        else             {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[N-1:1]};
      end else begin
        if (ge) begin
          acc_hi_d = sum[N-1:0];
          acc_lo_d = {acc_lo_q[N-2:0], 1'b1};
        end else begin
          acc_hi_d = {acc_hi_q[N-2:0], acc_lo_q[N-1]};
          acc_lo_d = {acc_lo_q[N-2:0], 1'b0};
        end
      end
    end else if (fix) begin
      if (is_mul) begin
        {hi_d, lo_d} = rsign_q ? -prod : prod;
      end else if (bmag_q == '0) begin
        hi_d = araw_q;
        lo_d = '1;
      end else begin
        lo_d = rsign_q ? -acc_lo_q : acc_lo_q;
        hi_d = dsign_q ? -acc_hi_q : acc_hi_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      amag_q   <= '0;
      bmag_q   <= '0;
      araw_q   <= '0;
      rsign_q  <= 1'b0;
      dsign_q  <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      op_q     <= op_d;
      amag_q   <= amag_d;
      bmag_q   <= bmag_d;
      araw_q   <= araw_d;
      rsign_q  <= rsign_d;
      dsign_q  <= dsign_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/seq_muldiv.sv
// Sequential MULT/MULTU/DIV/DIVU unit: controller FSM, iteration counter,
// start/busy/done handshake and the divide-by-zero flag around the datapath.
module seq_muldiv
  import seq_muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [1:0]   dbg_state
);

  // Handshake: start is sampled only in IDLE or DONE; busy covers CALC and
  // FIX; done pulses for the single DONE cycle with hi/lo already valid.

  localparam int CW = $clog2(N);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;
  logic          load, iter, fix;
  logic          dz_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    load    = 1'b0;
    iter    = 1'b0;
    fix     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CALC;
          load    = 1'b1;
          cnt_d   = CW'(N-1);
          dbz_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        iter = 1'b1;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIX: begin
        fix     = 1'b1;
        state_d = DONE;
        dbz_d   = dz_hit;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  muldiv_datapath #(.N(N)) u_dp (
    .clk    (clk),
    .rst_n  (rst),
    .load   (load),
    .iter   (iter),
    .fix    (fix),
    .op     (op),
    .a      (a),
    .b      (b),
    .hi     (hi),
    .lo     (lo),
    .dz_hit (dz_hit)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed bench for seq_muldiv (N=32): a table of hand-computed vectors plus
// sequences for divide-by-zero flag lifetime, back-to-back issue and reset abort.
module tb_seq_muldiv;
  import seq_muldiv_pkg::*;

  localparam int N = 32;

  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dbz;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int bcnt;
  vec_t vecs[11];
  logic [1:0] s_idle;
  logic [1:0] s_calc;

  seq_muldiv #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // drivers
  task automatic start_op(input logic [1:0] o, input logic [N-1:0] av,
                          input logic [N-1:0] bv, input bit hold);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Called #1 after the accept edge; cyc counts cycles with the first being 1.
  task automatic wait_done(output int c, output int bc);
    c  = 1;
    bc = busy ? 1 : 0;
    while (!done && c < 200) begin
      @(posedge clk);
      #1;
      c++;
      if (busy) bc++;
    end
    if (!done) check("done_timeout", 64'(done), 64'(1));
  endtask

  initial begin
    s_idle = IDLE;
    s_calc = CALC;
    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{OP_MULT,  32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0};
    vecs[9]  = '{OP_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    #23;
    check("rst_hi",    64'(hi), 64'(0));
    check("rst_lo",    64'(lo), 64'(0));
    check("rst_busy",  64'(busy), 64'(0));
    check("rst_done",  64'(done), 64'(0));
    check("rst_dbz",   64'(div_by_zero), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(s_idle));
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 11; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      wait_done(cyc, bcnt);
      check($sformatf("v%0d_hi", i),      64'(hi), 64'(vecs[i].hi));
      check($sformatf("v%0d_lo", i),      64'(lo), 64'(vecs[i].lo));
      check($sformatf("v%0d_dbz", i),     64'(div_by_zero), 64'(vecs[i].dbz));
      check($sformatf("v%0d_latency", i), 64'(cyc), 64'(N+2));
      check($sformatf("v%0d_busy", i),    64'(bcnt), 64'(N+1));
    end

    // divide-by-zero flag holds through idle, clears on next accept
    start_op(OP_DIVU, 32'd5, 32'd0, 1'b0);
    wait_done(cyc, bcnt);
    check("dz_flag", 64'(div_by_zero), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    check("dz_held_idle", 64'(div_by_zero), 64'(1));
    check("dz_idle_done", 64'(done), 64'(0));
    start_op(OP_DIVU, 32'd7, 32'd2, 1'b0);
    check("dz_cleared", 64'(div_by_zero), 64'(0));
    check("dz_hold_hi", 64'(hi), 64'(5));
    wait_done(cyc, bcnt);
    check("dz_next_lo", 64'(lo), 64'(3));

    // back-to-back: start held through CALC, new op issued in done cycle
    start_op(OP_MULTU, 32'd3, 32'd4, 1'b1);
    wait_done(cyc, bcnt);
    check("b2b_first_lat", 64'(cyc), 64'(N+2));
    check("b2b_first_hi",  64'(hi), 64'(0));
    check("b2b_first_lo",  64'(lo), 64'(12));
    op = OP_DIVU;
    a  = 32'd9;
    b  = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_accept_busy",  64'(busy), 64'(1));
    check("b2b_accept_state", 64'(dbg_state), 64'(s_calc));
    check("b2b_hold_lo",      64'(lo), 64'(12));
    wait_done(cyc, bcnt);
    check("b2b_second_lat", 64'(cyc), 64'(N+2));
    check("b2b_second_hi",  64'(hi), 64'(1));
    check("b2b_second_lo",  64'(lo), 64'(2));

    // asynchronous reset in CALC cycle 10 of a MULT
    start_op(OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hi",    64'(hi), 64'(0));
    check("arst_lo",    64'(lo), 64'(0));
    check("arst_busy",  64'(busy), 64'(0));
    check("arst_done",  64'(done), 64'(0));
    check("arst_dbz",   64'(div_by_zero), 64'(0));
    check("arst_state", 64'(dbg_state), 64'(s_idle));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_post_state", 64'(dbg_state), 64'(s_idle));
    start_op(OP_MULTU, 32'd2, 32'd3, 1'b0);
    wait_done(cyc, bcnt);
    check("arst_after_hi",  64'(hi), 64'(0));
    check("arst_after_lo",  64'(lo), 64'(6));
    check("arst_after_lat", 64'(cyc), 64'(N+2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_muldiv.md
# seq_muldiv

Parametrised sequential multiply/divide unit: the successor to the team's shift-add multiplier. It executes MIPS-style MULT, MULTU, DIV and DIVU on N-bit operands, one iteration per clock, and writes the results to HI/LO registers. It sits beside the ALU and is driven by the same start/busy/done handshake. Relative to the earlier multiplier it adds signed operation, restoring division, divide-by-zero reporting and back-to-back issue.

## Interface
Parameters:
- N, 32, operand width (N ≥ 4)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- op  in  2  operation, latched with start: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  in  N  multiplicand or dividend, latched with start
- b  in  N  multiplier or divisor, latched with start
- hi  out  N  MULT/MULTU: product[2N-1:N]; DIV/DIVU: remainder
- lo  out  N  MULT/MULTU: product[N-1:0]; DIV/DIVU: quotient
- busy  out  1  high in CALC and FIX
- done  out  1  one-cycle pulse while in DONE
- div_by_zero  out  1  set with done for DIV/DIVU when b == 0; held until the next accepted start

## Operation
- FSM states:
  - IDLE: start=1 goes to CALC.
  - CALC: runs for exactly N cycles, then goes to FIX.
  - FIX: goes to DONE.
  - DONE: start=1 goes to CALC; otherwise goes to IDLE.
- Accept (IDLE/DONE with start=1):
  - Latch op.
  - Latch |a| and |b| as N-bit unsigned magnitudes. Signed ops take two's-complement magnitude; 0x80..0 maps to 2^(N-1) and fits in N bits.
  - Record the result sign (a[N-1]^b[N-1]) and the dividend sign (a[N-1]), both for signed ops only.
  - Load the iteration counter with N-1.
  - Clear div_by_zero.
- Multiply iteration (CALC):
  - If the low bit of the running product is 1, add the multiplicand into the upper half using an (N+1)-bit sum.
  - Shift the 2N+1-bit accumulator right by 1.
- Divide iteration (CALC), restoring:
  - Shift {rem, quo} left by 1.
  - trial = rem − divisor, computed N+1 bits wide.
  - If trial ≥ 0: rem = trial and set the quotient LSB.
- FIX:
  - Apply sign correction. Product is negated (2N bits) if the result sign is set. Quotient is negated if the result sign is set. Remainder is negated if the dividend sign is set.
  - Write hi/lo.
  - If a divide has b == 0: override to hi = a (raw input as latched), lo = all ones, and set div_by_zero.
- Arithmetic rules:
  - All negation is two's-complement modulo the field width.
  - DIV 0x80..0 / −1 gives lo = 0x80..0 and hi = 0; no flag is raised.
  - The remainder always has the dividend's sign; |rem| < |b|.
- hi/lo change only in FIX. They hold their value through IDLE, DONE and the next CALC.
- start during CALC or FIX is ignored; it is not queued.
- Operand inputs are don't-care outside the accept cycle.

## Timing
- Reset (asynchronous assert, any state): state = IDLE; hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0. Reset mid-operation aborts with no partial write.
- Accept at edge k:
  - busy is high from cycle k+1 through edge k+N+1.
  - hi/lo/div_by_zero are valid after edge k+N+1.
  - done is high during cycle k+N+2 only.
- Latency is N+2 cycles for every op; there is no early termination.
- Back-to-back: start asserted in the done cycle is accepted. busy rises on the next edge, giving a throughput of one op per N+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package seq_muldiv_pkg:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - FSM state enum (IDLE, CALC, FIX, DONE)
- Top level seq_muldiv: FSM, counter, handshake and div_by_zero.
- Sub-module muldiv_datapath: magnitude/sign capture, shared (N+1)-bit adder/subtractor, accumulator, and FIX sign correction. It is steered by the FSM's load, iterate and fix strobes.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF (N=32) -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after the accept edge; busy high for 33 cycles.
- MULT a=0xFFFFFFFD (−3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- DIV a=−7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- DIVU a=5, b=0 -> hi=5, lo=0xFFFFFFFF, div_by_zero=1 with done. The next accepted start clears div_by_zero one edge after accept.
- Run MULTU 3×4, hold start high through CALC, then issue DIVU 9/4 in the done cycle:
  - the first result is hi=0, lo=12;
  - the mid-op start is ignored;
  - the second op is accepted immediately and gives hi=1, lo=2, with done N+2 cycles later.
- Assert rst low at CALC cycle 10 of a MULT -> all outputs 0 asynchronously and the FSM is in IDLE. After release, MULTU 2×3 completes normally with lo=6.
